mipi_rffe_master: RTL and testbench

//  MIPI RFFE serial master: turns one decoded register command (REG_WR/REG_RD/EXT_WR/EXT_RD) into an RFFE bus sequence.
//  The sequence is SSC, command frame, optional address frame, data frames, then bus park.

---
 rtl/mipi_rffe_master_pkg.sv | 50 +++++
 rtl/rffe_bit_timer.sv | 47 ++++
 rtl/mipi_rffe_master.sv | 208 ++++++++++++++++++++
 tb/tb_mipi_rffe_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_rffe_master_pkg.sv
// Shared command codes, opcode prefixes, FSM state type and frame builders for the RFFE master.
package mipi_rffe_master_pkg;

  typedef enum logic [1:0] {
    CmdRegWr = 2'd0,
    CmdRegRd = 2'd1,
    CmdExtWr = 2'd2,
    CmdExtRd = 2'd3
  } rffe_cmd_e;

  localparam logic [2:0] OpRegWr = 3'b010;
  localparam logic [2:0] OpRegRd = 3'b011;
  localparam logic [5:0] OpExtWr = 6'b000000;
  localparam logic [5:0] OpExtRd = 6'b001000;

  typedef enum logic [3:0] {
    StIdle,
    StSsc1,
    StSsc0,
    StCmd,
    StAddr,
    StWrData,
    StRdTa,
    StRdData,
    StPark,
    StDone
  } rffe_state_e;

  function automatic logic [7:0] cmd8(input rffe_cmd_e c, input logic [7:0] addr,
                                      input logic [1:0] bc);
    logic [7:0] r;
    unique case (c)
      CmdRegWr: r = {OpRegWr, addr[4:0]};
      CmdRegRd: r = {OpRegRd, addr[4:0]};
      CmdExtWr: r = {OpExtWr, bc};
      CmdExtRd: r = {OpExtRd, bc};
    endcase
    return r;
  endfunction

  // Frames are left-aligned in the 13-bit shifter so bit 12 is always the next bit out.
  function automatic logic [12:0] cmd_frame(input logic [3:0] id, input logic [7:0] c8);
    return {id, c8, ~^{id, c8}};
  endfunction

  function automatic logic [12:0] byte_frame(input logic [7:0] b);
    return {b, ~^b, 4'b0000};
  endfunction

endpackage

// File: rtl/rffe_bit_timer.sv
// SCLK slot timer: each bit slot is CLK_DIV clks of SCLK high followed by CLK_DIV clks low.
module rffe_bit_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic hi_o,
  output logic fall_stb_o,
  output logic slot_end_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            half_q, half_d;

  always_comb begin
    div_d  = div_q;
    half_d = half_q;
    if (clr_i) begin
      div_d  = '0;
      half_d = 1'b0;
    end else if (div_q == DivMax) begin
      div_d  = '0;
      half_d = ~half_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      half_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      half_q <= half_d;
    end
  end

  assign hi_o       = ~half_q;
  assign fall_stb_o = ~half_q & (div_q == DivMax);
  assign slot_end_o = half_q & (div_q == DivMax);

endmodule

// File: rtl/mipi_rffe_master.sv
// RFFE serial master: plays one register command out as SSC, frames and bus park on SCLK/SDATA.
module mipi_rffe_master
  import mipi_rffe_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  cmd_type_i,
  input  logic [3:0]  slave_id_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [1:0]  byte_cnt_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        parity_err_o,
  output logic        sclk_o,
  output logic        sdo_o,
  output logic        sdo_en_o,
  input  logic        sdi_i
);

  rffe_state_e state_q, state_d;
  rffe_cmd_e   cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [12:0] sh_q, sh_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        par_q, par_d;
  logic [31:0] rdata_q, rdata_d;
  logic        perr_q, perr_d;

  logic accept, hi, fall_stb, slot_end;
  logic is_ext, is_rd, frame_last, byte_last;

  assign accept     = start_i & (state_q == StIdle);
  assign is_ext     = (cmd_q == CmdExtWr) || (cmd_q == CmdExtRd);
  assign is_rd      = (cmd_q == CmdRegRd) || (cmd_q == CmdExtRd);
  assign frame_last = (state_q == StCmd) ? (bit_q == 4'd12) : (bit_q == 4'd8);
  assign byte_last  = !is_ext || (byte_q == bcnt_q);

  rffe_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (accept),
    .hi_o       (hi),
    .fall_stb_o (fall_stb),
    .slot_end_o (slot_end)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    wdata_d = wdata_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    par_d   = par_q;
    rdata_d = rdata_q;
    perr_d  = perr_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cmd_d   = rffe_cmd_e'(cmd_type_i);
          addr_d  = reg_addr_i;
          bcnt_d  = byte_cnt_i;
          wdata_d = wdata_i;
          sh_d    = cmd_frame(slave_id_i, cmd8(rffe_cmd_e'(cmd_type_i), reg_addr_i, byte_cnt_i));
          bit_d   = '0;
          byte_d  = '0;
          par_d   = 1'b0;
          rdata_d = '0;
          perr_d  = 1'b0;
          state_d = StSsc1;
        end
      end
      StSsc1: if (slot_end) state_d = StSsc0;
      StSsc0: if (slot_end) state_d = StCmd;
      StCmd, StAddr, StWrData: begin
        if (slot_end) begin
          if (!frame_last) begin
            sh_d  = {sh_q[11:0], 1'b0};
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d = '0;
            if (state_q == StCmd && is_ext) begin
              sh_d    = byte_frame(addr_q);
              state_d = StAddr;
            end else if (state_q != StWrData) begin
              if (is_rd) begin
                state_d = StRdTa;
              end else begin
                sh_d    = byte_frame(wdata_q[7:0]);
                state_d = StWrData;
              end
            end else if (byte_last) begin
              state_d = StPark;
            end else begin
              // Consumed bytes are shifted out so the next one always sits at [15:8].
              byte_d  = byte_q + 2'd1;
              sh_d    = byte_frame(wdata_q[15:8]);
              wdata_d = wdata_q >> 8;
            end
          end
        end
      end
      StRdTa: begin
        if (slot_end) begin
          bit_d   = '0;
          par_d   = 1'b0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (fall_stb) begin
          sh_d  = {sh_q[11:0], sdi_i};
          par_d = par_q ^ sdi_i;
        end
        if (slot_end) begin
          if (!frame_last) begin
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d = '0;
            par_d = 1'b0;
            if (!par_q) perr_d = 1'b1;
            rdata_d[{byte_q, 3'b000} +: 8] = sh_q[8:1];
            if (byte_last) state_d = StPark;
            else byte_d = byte_q + 2'd1;
          end
        end
      end
      StPark: if (slot_end) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cmd_q   <= CmdRegWr;
      addr_q  <= '0;
      bcnt_q  <= '0;
      wdata_q <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      wdata_q <= wdata_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Pins decode straight from registered state so an async reset idles the bus at once.
  always_comb begin
    sclk_o   = 1'b0;
    sdo_o    = 1'b0;
    sdo_en_o = 1'b0;
    unique case (state_q)
      StSsc1: begin
        sdo_o    = 1'b1;
        sdo_en_o = 1'b1;
      end
      StSsc0: sdo_en_o = 1'b1;
      StCmd, StAddr, StWrData: begin
        sclk_o   = hi;
        sdo_o    = sh_q[12];
        sdo_en_o = 1'b1;
      end
      StRdTa: begin
        sclk_o   = hi;
        sdo_en_o = hi;
      end
      StRdData: sclk_o = hi;
      StPark: begin
        sclk_o   = hi;
        sdo_en_o = hi & ~is_rd;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != StIdle) && (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign rdata_o      = rdata_q;
  assign parity_err_o = perr_q;

endmodule

// File: tb/tb_mipi_rffe_master.sv
// Directed bench for mipi_rffe_master: vector table for whole transactions plus start/reset corners.
module tb_mipi_rffe_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [1:0]  cmd_type;
  logic [3:0]  slave_id;
  logic [7:0]  reg_addr;
  logic [1:0]  byte_cnt;
  logic [31:0] wdata;
  logic        sdi;

  logic        busy_a, done_a, perr_a, sclk_a, sdo_a, sdo_en_a;
  logic        busy_b, done_b, perr_b, sclk_b, sdo_b, sdo_en_b;
  logic [31:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mipi_rffe_master #(
    .CLK_DIV(2)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_a),
    .cmd_type_i   (cmd_type),
    .slave_id_i   (slave_id),
    .reg_addr_i   (reg_addr),
    .byte_cnt_i   (byte_cnt),
    .wdata_i      (wdata),
    .busy_o       (busy_a),
    .done_o       (done_a),
    .rdata_o      (rdata_a),
    .parity_err_o (perr_a),
    .sclk_o       (sclk_a),
    .sdo_o        (sdo_a),
    .sdo_en_o     (sdo_en_a),
    .sdi_i        (sdi)
  );

  mipi_rffe_master #(
    .CLK_DIV(1)
  ) u_dut_div1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_b),
    .cmd_type_i   (cmd_type),
    .slave_id_i   (slave_id),
    .reg_addr_i   (reg_addr),
    .byte_cnt_i   (byte_cnt),
    .wdata_i      (wdata),
    .busy_o       (busy_b),
    .done_o       (done_b),
    .rdata_o      (rdata_b),
    .parity_err_o (perr_b),
    .sclk_o       (sclk_b),
    .sdo_o        (sdo_b),
    .sdo_en_o     (sdo_en_b),
    .sdi_i        (sdi)
  );

  typedef struct {
    int          sel;     // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
    logic [1:0]  cmd;
    logic [3:0]  id;
    logic [7:0]  addr;
    logic [1:0]  bcnt;
    logic [31:0] wdata;
    logic [35:0] sbits;   // slave read bits, left-aligned
    int          sn;
    logic [63:0] tx;      // master-driven bits, left-aligned
    int          ntx;
    int          nslots;
    int          lat;
    logic [31:0] rdata;
    logic        perr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string what, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", what, got, exp);
    end
  endtask

  // Master drives SDATA through every frame slot; the slot right after the last master
  // frame (turnaround or write park) is driven only during its high half.
  function automatic logic exp_en(input vec_t v, input int s, input logic hi);
    if (s < v.ntx) return 1'b1;
    if (s == v.ntx) return hi;
    return 1'b0;
  endfunction

  task automatic run_vec(input int r, input vec_t v, input int pulse_at, input bit idle_chk);
    int n, slot, ssc1, ssc0, done_at, en_bad, sdo_bad, div;
    logic prev, s_sclk, s_sdo, s_en, s_busy, s_done, busy_at_done, pe;
    logic [31:0] rd;
    logic [35:0] tmp;
    logic [63:0] got_tx;
    div = (v.sel != 0) ? 1 : 2;
    cmd_type = v.cmd; slave_id = v.id; reg_addr = v.addr; byte_cnt = v.bcnt; wdata = v.wdata;
    sdi = 1'b0;
    if (v.sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    n = 1; slot = 0; ssc1 = 0; ssc0 = 0; done_at = -1; en_bad = 0; sdo_bad = 0;
    prev = 1'b0; got_tx = '0; busy_at_done = 1'b1; pe = 1'bx; rd = 'x;
    while (n <= 600 && done_at < 0) begin
      if (pulse_at > 0 && n == pulse_at) begin
        start_a = 1'b1; cmd_type = 2'd1; reg_addr = 8'h55; wdata = 32'h0;
      end else if (pulse_at > 0 && n == pulse_at + 1) begin
        start_a = 1'b0;
      end
      s_sclk = (v.sel != 0) ? sclk_b : sclk_a;
      s_sdo  = (v.sel != 0) ? sdo_b : sdo_a;
      s_en   = (v.sel != 0) ? sdo_en_b : sdo_en_a;
      s_busy = (v.sel != 0) ? busy_b : busy_a;
      s_done = (v.sel != 0) ? done_b : done_a;
      if (s_done) begin
        done_at      = n;
        busy_at_done = s_busy;
        rd           = (v.sel != 0) ? rdata_b : rdata_a;
        pe           = (v.sel != 0) ? perr_b : perr_a;
      end else begin
        if (s_sclk && !prev) begin
          if (slot < v.ntx) got_tx = {got_tx[62:0], s_sdo};
          else if (s_sdo !== 1'b0) sdo_bad++;
          if (s_en !== exp_en(v, slot, 1'b1)) en_bad++;
          if (v.sn > 0 && slot > v.ntx && slot <= v.ntx + v.sn) begin
            tmp = v.sbits << (slot - v.ntx - 1);
            sdi = tmp[35];
          end else begin
            sdi = 1'b0;
          end
          slot++;
        end else if (!s_sclk && slot == 0) begin
          if (s_sdo && s_en) ssc1++;
          else if (!s_sdo && s_en) ssc0++;
        end else if (!s_sclk) begin
          if (s_en !== exp_en(v, slot - 1, 1'b0)) en_bad++;
        end
        prev = s_sclk;
        @(negedge clk);
        n++;
      end
    end
    sdi = 1'b0;
    got_tx = got_tx << (64 - v.ntx);
    check($sformatf("row%0d ssc1 clks", r), 64'(ssc1), 64'(2 * div));
    check($sformatf("row%0d ssc0 clks", r), 64'(ssc0), 64'(2 * div));
    check($sformatf("row%0d slot count", r), 64'(slot), 64'(v.nslots));
    check($sformatf("row%0d sdo bits", r), got_tx, v.tx);
    check($sformatf("row%0d sdo_en pattern errors", r), 64'(en_bad), 64'(0));
    check($sformatf("row%0d sdo after frames errors", r), 64'(sdo_bad), 64'(0));
    check($sformatf("row%0d done latency", r), 64'(done_at), 64'(v.lat));
    check($sformatf("row%0d busy with done", r), 64'(busy_at_done), 64'(0));
    check($sformatf("row%0d rdata", r), 64'(rd), 64'(v.rdata));
    check($sformatf("row%0d parity_err", r), 64'(pe), 64'(v.perr));
    if (idle_chk) begin
      @(negedge clk);
      s_sclk = (v.sel != 0) ? sclk_b : sclk_a;
      s_en   = (v.sel != 0) ? sdo_en_b : sdo_en_a;
      s_busy = (v.sel != 0) ? busy_b : busy_a;
      s_done = (v.sel != 0) ? done_b : done_a;
      check($sformatf("row%0d idle after done", r), 64'({s_sclk, s_en, s_busy, s_done}), 64'(0));
    end
  endtask

  initial begin
    bit got_done;
    // sel, cmd, id, addr, bcnt, wdata, sbits, sn, tx, ntx, nslots, lat, rdata, perr
    vecs[0] = '{0, 2'd0, 4'd7, 8'h1C, 2'd0, 32'h000000A5, 36'd0, 0,
                {22'b0111_0101_1100_0_1010_0101_1, 42'd0}, 22, 23, 101, 32'h0, 1'b0};
    vecs[1] = '{0, 2'd1, 4'd7, 8'h02, 2'd0, 32'h0, {9'b0011_1100_1, 27'd0}, 9,
                {13'b0111_0110_0010_1, 51'd0}, 13, 24, 105, 32'h0000003C, 1'b0};
    vecs[2] = '{0, 2'd1, 4'd7, 8'h02, 2'd0, 32'h0, {9'b0011_1100_0, 27'd0}, 9,
                {13'b0111_0110_0010_1, 51'd0}, 13, 24, 105, 32'h0000003C, 1'b1};
    vecs[3] = '{0, 2'd2, 4'd2, 8'h40, 2'd3, 32'hDEADBEEF, 36'd0, 0,
                {58'b0010_0000_0011_0_0100_0000_0_1110_1111_0_1011_1110_1_1010_1101_0_1101_1110_1,
                 6'd0}, 58, 59, 245, 32'h0, 1'b0};
    vecs[4] = '{0, 2'd3, 4'd2, 8'h10, 2'd1, 32'h0, {18'b0001_0010_1_0011_0100_0, 18'd0}, 18,
                {22'b0010_0010_0001_0_0001_0000_0, 42'd0}, 22, 42, 177, 32'h00003412, 1'b0};
    vecs[5] = '{1, 2'd0, 4'd7, 8'h1C, 2'd0, 32'h000000A5, 36'd0, 0,
                {22'b0111_0101_1100_0_1010_0101_1, 42'd0}, 22, 23, 51, 32'h0, 1'b0};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sdi = 1'b0;
    cmd_type = '0; slave_id = '0; reg_addr = '0; byte_cnt = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset idle a", 64'({sclk_a, sdo_a, sdo_en_a, busy_a, done_a, perr_a}), 64'(0));
    check("reset rdata a", 64'(rdata_a), 64'(0));
    check("reset idle b", 64'({sclk_b, sdo_b, sdo_en_b, busy_b, done_b, perr_b}), 64'(0));
    check("reset rdata b", 64'(rdata_b), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) run_vec(r, vecs[r], 0, 1'b1);

    // Start mid-transfer (with other inputs changed) and in the DONE cycle must be ignored.
    run_vec(6, vecs[0], 30, 1'b0);
    start_a = 1'b1;
    @(negedge clk);
    check("start in done cycle ignored", 64'(busy_a), 64'(0));
    @(negedge clk);
    check("start after done accepted", 64'(busy_a), 64'(1));
    start_a = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 400 && !got_done; k++) begin
      if (done_a) got_done = 1'b1;
      else @(negedge clk);
    end
    check("follow-on transaction done", 64'(got_done), 64'(1));
    @(negedge clk);

    // Asynchronous reset in the middle of the CMD frame.
    cmd_type = vecs[0].cmd; slave_id = vecs[0].id; reg_addr = vecs[0].addr;
    byte_cnt = vecs[0].bcnt; wdata = vecs[0].wdata;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (12) @(negedge clk);
    check("mid cmd bus active", 64'({sclk_a, sdo_a, sdo_en_a, busy_a}), 64'(4'b1111));
    rst = 1'b1;
    #1;
    check("reset mid cmd idles at once", 64'({sclk_a, sdo_a, sdo_en_a, busy_a, done_a}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(7, vecs[0], 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
